// File: rtl/rr_mux_reg.sv
// rtl/rr_mux_reg.sv - N-channel round-robin mux with valid/ready inputs and one registered output stage.
// Optional packet lock (in_last/out_last) is enabled by defining RR_MUX_PACKET_LOCK_EN.
module rr_mux_reg #(
  parameter int N_CH = 4,
  parameter int W    = 8,
  parameter int CH_W = ($clog2(N_CH) > 0 ? $clog2(N_CH) : 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   in_valid,
  input  logic [N_CH*W-1:0] in_data,
`ifdef RR_MUX_PACKET_LOCK_EN
  input  logic [N_CH-1:0]   in_last,
  output logic              out_last,
`endif
  output logic [N_CH-1:0]   in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  output logic [CH_W-1:0]   out_ch,
  input  logic              out_ready
);

  localparam int SW = CH_W + 1;

  logic [W-1:0]    ch_data [N_CH];
  logic            out_valid_q, out_valid_d;
  logic [W-1:0]    out_data_q, out_data_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [CH_W-1:0] ptr_q, ptr_d;
  logic [N_CH-1:0] grant;
  logic [CH_W-1:0] grant_idx;
  logic [CH_W-1:0] cand;
  logic [SW-1:0]   sum;
  logic [CH_W-1:0] ptr_inc;
  logic            found;
  logic            load;
  logic            xfer;
`ifdef RR_MUX_PACKET_LOCK_EN
  logic            lock_q, lock_d;
  logic            out_last_q, out_last_d;
`endif

  for (genvar i = 0; i < N_CH; i++) begin : g_unpack
    assign ch_data[i] = in_data[i*W +: W];
  end

  // Scan channels starting at ptr, wrapping, and keep the first valid one.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    sum       = '0;
    cand      = '0;
    for (int k = 0; k < N_CH; k++) begin
      sum = {1'b0, ptr_q} + SW'(k);
      if (sum >= SW'(N_CH)) sum = sum - SW'(N_CH);
      cand = sum[CH_W-1:0];
      if (!found && in_valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
`ifdef RR_MUX_PACKET_LOCK_EN
    // While a packet is open only its channel may be granted; out_ch_q holds it.
    if (lock_q) begin
      grant     = '0;
      grant_idx = out_ch_q;
      if (in_valid[out_ch_q]) grant[out_ch_q] = 1'b1;
    end
`endif
  end

  assign load     = ~out_valid_q | out_ready;
  assign in_ready = (load && !rst) ? grant : '0;
  assign xfer     = |in_ready;
  assign ptr_inc  = (grant_idx == CH_W'(N_CH - 1)) ? '0 : grant_idx + CH_W'(1);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
`ifdef RR_MUX_PACKET_LOCK_EN
    lock_d      = lock_q;
    out_last_d  = out_last_q;
`endif
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[grant_idx];
      out_ch_d    = grant_idx;
`ifdef RR_MUX_PACKET_LOCK_EN
      out_last_d  = in_last[grant_idx];
      lock_d      = ~in_last[grant_idx];
      if (in_last[grant_idx]) ptr_d = ptr_inc;
`else
      ptr_d       = ptr_inc;
`endif
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
`ifdef RR_MUX_PACKET_LOCK_EN
      lock_q      <= 1'b0;
      out_last_q  <= 1'b0;
`endif
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
`ifdef RR_MUX_PACKET_LOCK_EN
      lock_q      <= lock_d;
      out_last_q  <= out_last_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
`ifdef RR_MUX_PACKET_LOCK_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_rr_mux_reg.sv
// tb/tb_rr_mux_reg.sv - directed self-checking bench for rr_mux_reg (N_CH=4, W=8).
module tb_rr_mux_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_valid;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_ready;
`ifdef RR_MUX_PACKET_LOCK_EN
  logic [3:0]  in_last;
  logic        out_last;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rr_mux_reg #(.N_CH(4), .W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
`ifdef RR_MUX_PACKET_LOCK_EN
    .in_last(in_last), .out_last(out_last),
`endif
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_ch(out_ch), .out_ready(out_ready)
  );

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data got %h exp 00", out_data); end
      n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL reset_out_ch got %0d exp 0", out_ch); end
      n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
    end
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL post_reset_in_ready got %b exp 0001", in_ready); end
  endtask

  task automatic test_round_robin();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_valid[%0d] got %b exp 1", k, out_valid); end
      n_cmp++; if (out_ch !== 2'(k % 4)) begin n_fail++; $display("FAIL rr_ch[%0d] got %0d exp %0d", k, out_ch, k % 4); end
      n_cmp++; if (out_data !== 8'hA0 + 8'(k % 4)) begin n_fail++; $display("FAIL rr_data[%0d] got %h exp %h", k, out_data, 8'hA0 + 8'(k % 4)); end
    end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    n_cmp++; if (out_data !== 8'hA2) begin n_fail++; $display("FAIL bp_first_data got %h exp a2", out_data); end
    out_ready = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready_now got %b exp 0000", in_ready); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d] got %b exp 1", c, out_valid); end
      n_cmp++; if (out_data !== 8'hA2) begin n_fail++; $display("FAIL bp_data[%0d] got %h exp a2", c, out_data); end
      n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_in_ready[%0d] got %b exp 0000", c, in_ready); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_release_ready got %b exp 1000", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_ch !== 2'd3) begin n_fail++; $display("FAIL bp_next_ch got %0d exp 3", out_ch); end
    n_cmp++; if (out_data !== 8'hA3) begin n_fail++; $display("FAIL bp_next_data got %h exp a3", out_data); end
  endtask

  task automatic test_sparse();
    in_valid = 4'b0001;
    @(negedge clk);
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL sparse_a_ch got %0d exp 0", out_ch); end
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL sparse_b_ready got %b exp 0001", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL sparse_b_ch got %0d exp 0", out_ch); end
    n_cmp++; if (out_data !== 8'hA0) begin n_fail++; $display("FAIL sparse_b_data got %h exp a0", out_data); end
    in_valid = 4'b1001;
    #1;
    n_cmp++; if (in_ready !== 4'b1000) begin n_fail++; $display("FAIL sparse_c_ready got %b exp 1000", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_ch !== 2'd3) begin n_fail++; $display("FAIL sparse_c_ch got %0d exp 3", out_ch); end
    n_cmp++; if (out_data !== 8'hA3) begin n_fail++; $display("FAIL sparse_c_data got %h exp a3", out_data); end
  endtask

  task automatic test_async_reset();
    in_valid = 4'b0010;
    @(negedge clk);
    n_cmp++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL ar_pre_ch got %0d exp 1", out_ch); end
    in_valid  = 4'b0000;
    out_ready = 1'b0;
    @(negedge clk);
    n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ar_held_valid got %b exp 1", out_valid); end
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid_async got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL ar_data_async got %h exp 00", out_data); end
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL ar_ch_async got %0d exp 0", out_ch); end
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL ar_ready_in_rst got %b exp 0000", in_ready); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL ar_first_ready got %b exp 0001", in_ready); end
    @(negedge clk);
    n_cmp++; if (out_ch !== 2'd0) begin n_fail++; $display("FAIL ar_first_ch got %0d exp 0", out_ch); end
    n_cmp++; if (out_data !== 8'hA0) begin n_fail++; $display("FAIL ar_first_data got %h exp a0", out_data); end
  endtask

`ifdef RR_MUX_PACKET_LOCK_EN
  task automatic test_packet_lock();
    logic [2:0] lasts;
    lasts    = 3'b100;
    in_valid = 4'b0110;
    for (int b = 0; b < 3; b++) begin
      in_last = {1'b0, 1'b1, lasts[b], 1'b0};
      @(negedge clk);
      n_cmp++; if (out_ch !== 2'd1) begin n_fail++; $display("FAIL lock_ch[%0d] got %0d exp 1", b, out_ch); end
      n_cmp++; if (out_last !== lasts[b]) begin n_fail++; $display("FAIL lock_last[%0d] got %b exp %b", b, out_last, lasts[b]); end
    end
    @(negedge clk);
    n_cmp++; if (out_ch !== 2'd2) begin n_fail++; $display("FAIL lock_after_ch got %0d exp 2", out_ch); end
  endtask
`endif

  initial begin
    rst       = 1'b1;
    in_valid  = 4'b1111;
    in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    out_ready = 1'b1;
`ifdef RR_MUX_PACKET_LOCK_EN
    in_last   = 4'b1111;
`endif
    test_reset();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_async_reset();
`ifdef RR_MUX_PACKET_LOCK_EN
    test_packet_lock();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
